// File: rtl/tlul_host_adapter_pkg.sv
// Shared TL-UL types and helpers for the host adapter slice.
// Holds the A/D channel structs, opcode enums, the word-size constant and
// the vbits() width helper used to size counters and pointers.
package tlul_host_adapter_pkg;

  localparam int unsigned TL_AW  = 32;
  localparam int unsigned TL_DW  = 32;
  localparam int unsigned TL_AIW = 8;
  localparam int unsigned TL_DIW = 1;
  localparam int unsigned TL_DBW = TL_DW / 8;
  localparam int unsigned TL_SZW = 2;

  localparam logic [TL_SZW-1:0] TL_SZ_WORD = TL_SZW'(2);

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_m_op;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_m_op;

  typedef struct packed {
    logic                a_valid;
    tl_a_m_op            a_opcode;
    logic [2:0]          a_param;
    logic [TL_SZW-1:0]   a_size;
    logic [TL_AIW-1:0]   a_source;
    logic [TL_AW-1:0]    a_address;
    logic [TL_DBW-1:0]   a_mask;
    logic [TL_DW-1:0]    a_data;
    logic                d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                d_valid;
    tl_d_m_op            d_opcode;
    logic [2:0]          d_param;
    logic [TL_SZW-1:0]   d_size;
    logic [TL_AIW-1:0]   d_source;
    logic [TL_DIW-1:0]   d_sink;
    logic [TL_DW-1:0]    d_data;
    logic                d_error;
    logic                a_ready;
  } tl_d2h_t;

  // Bits needed to hold values 0..value-1; never less than one.
  function automatic int unsigned vbits(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/tlul_host_adapter_if.sv
// Core-side memory port: req/gnt request handshake plus rvalid response.
// Signal suffixes are from the adapter's point of view.
//   master : the core (drives req/we/addr/be/wdata)
//   slave  : the adapter (drives gnt/rvalid/rdata/err)
interface tlul_host_adapter_if;
  import tlul_host_adapter_pkg::*;

  logic              req_i;
  logic              gnt_o;
  logic              we_i;
  logic [TL_AW-1:0]  addr_i;
  logic [TL_DBW-1:0] be_i;
  logic [TL_DW-1:0]  wdata_i;
  logic              rvalid_o;
  logic [TL_DW-1:0]  rdata_o;
  logic              err_o;

  modport master (
    output req_i, we_i, addr_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );

endinterface

// File: rtl/tlul_host_adapter_dir.sv
// tlul_dir_fifo: 1-bit fall-through FIFO holding the write/read direction of
// each outstanding request, so the D beat opcode can be checked in order.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i       : store wdata_i at the tail
//   wdata_i      : direction bit (1 = write)
//   pop_i        : drop the head entry
//   rdata_o      : head entry, valid whenever the FIFO is non-empty
// The owner never pushes when full nor pops when empty.
module tlul_dir_fifo import tlul_host_adapter_pkg::*; #(
  parameter int unsigned Depth = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic wdata_i,
  input  logic pop_i,
  output logic rdata_o
);

  localparam int unsigned PtrW = vbits(Depth);

  logic [Depth-1:0] mem_q, mem_d;
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_i) begin
      mem_d[wptr_q] = wdata_i;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (pop_i) begin
      rptr_d = ptr_inc(rptr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  assign rdata_o = mem_q[rptr_q];

endmodule

// File: rtl/tlul_host_adapter.sv
// TL-UL host adapter: converts a core req/gnt/rvalid port into TL-UL A-channel
// requests and returns D-channel responses to the core in request order.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   core_io      : core-side port (slave modport)
//   tl_o         : A-channel request and d_ready
//   tl_i         : D-channel response and a_ready
// Misaligned requests are answered locally with an error and never issued.
module tlul_host_adapter import tlul_host_adapter_pkg::*; #(
  parameter int unsigned       MAX_REQS  = 2,
  parameter logic [TL_AIW-1:0] SOURCE_ID = 8'h00
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  tlul_host_adapter_if.slave        core_io,
  output tl_h2d_t                   tl_o,
  input  tl_d2h_t                   tl_i
);

  localparam int unsigned CntW = vbits(MAX_REQS + 1);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             lerr_q;
  logic             rvalid_q, rvalid_d;
  logic [TL_DW-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  logic aligned, bus_valid, bus_gnt, local_gnt, d_exp, head_we, d_err;

  assign aligned   = (core_io.addr_i[1:0] == 2'b00);
  assign bus_valid = core_io.req_i & aligned & (cnt_q < CntW'(MAX_REQS)) & ~rst_i;
  assign bus_gnt   = bus_valid & tl_i.a_ready;
  // Local errors wait for the bus to drain so responses stay in order.
  assign local_gnt = core_io.req_i & ~aligned & (cnt_q == '0) & ~lerr_q & ~tl_i.d_valid & ~rst_i;
  assign d_exp     = tl_i.d_valid & (cnt_q != '0);

  assign core_io.gnt_o = bus_gnt | local_gnt;

  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = bus_valid;
    if (!core_io.we_i) begin
      tl_o.a_opcode = Get;
    end else if (core_io.be_i == 4'hF) begin
      tl_o.a_opcode = PutFullData;
    end else begin
      tl_o.a_opcode = PutPartialData;
    end
    tl_o.a_param   = 3'b000;
    tl_o.a_size    = TL_SZ_WORD;
    tl_o.a_source  = SOURCE_ID;
    tl_o.a_address = {core_io.addr_i[31:2], 2'b00};
    tl_o.a_mask    = core_io.we_i ? core_io.be_i : 4'hF;
    tl_o.a_data    = core_io.wdata_i;
    tl_o.d_ready   = 1'b1;
  end

  tlul_dir_fifo #(
    .Depth (MAX_REQS)
  ) u_dir_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (bus_gnt),
    .wdata_i (core_io.we_i),
    .pop_i   (d_exp),
    .rdata_o (head_we)
  );

  // Writes expect AccessAck, reads AccessAckData.
  assign d_err = tl_i.d_error | (tl_i.d_source != SOURCE_ID) |
                 (head_we ? (tl_i.d_opcode != AccessAck) : (tl_i.d_opcode != AccessAckData));

  always_comb begin
    cnt_d = cnt_q;
    if (bus_gnt && !d_exp) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!bus_gnt && d_exp) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_comb begin
    rvalid_d = d_exp | local_gnt;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (d_exp) begin
      rdata_d = head_we ? '0 : tl_i.d_data;
      err_d   = d_err;
    end else if (local_gnt) begin
      rdata_d = '0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      lerr_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      lerr_q   <= local_gnt;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign core_io.rvalid_o = rvalid_q;
  assign core_io.rdata_o  = rdata_q;
  assign core_io.err_o    = err_q;

  logic unused_d;
  assign unused_d = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink};

endmodule

// File: tb/tb_tlul_host_adapter.sv
// Bench for tlul_host_adapter: directed stimulus, a queue-based response model
// checked every cycle, plus hand-computed literal expectations.
module tb_tlul_host_adapter;
  import tlul_host_adapter_pkg::*;

  localparam int unsigned MaxReqs = 2;
  localparam logic [7:0]  Sid     = 8'h00;

  logic    clk = 1'b0;
  logic    rst;
  tl_h2d_t tl_h2d;
  tl_d2h_t tl_d2h;

  always #5 clk = ~clk;

  tlul_host_adapter_if core ();

  tlul_host_adapter #(
    .MAX_REQS  (MaxReqs),
    .SOURCE_ID (Sid)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .core_io (core),
    .tl_o    (tl_h2d),
    .tl_i    (tl_d2h)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: outstanding directions in a queue, plus the response due this cycle.
  bit          m_dir[$];
  bit          m_pend_local = 1'b0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0;
  bit          m_rdata_dc = 1'b0;
  bit          cmp_en = 1'b0;

  function automatic bit exp_a_valid();
    return core.req_i && (core.addr_i[1:0] == 2'b00) && (m_dir.size() < MaxReqs) && !rst;
  endfunction

  function automatic bit exp_loc_gnt();
    return core.req_i && (core.addr_i[1:0] != 2'b00) && (m_dir.size() == 0) &&
           !m_pend_local && !tl_d2h.d_valid && !rst;
  endfunction

  function automatic logic [2:0] exp_op();
    if (!core.we_i) return Get;
    if (core.be_i == 4'hF) return PutFullData;
    return PutPartialData;
  endfunction

  initial forever begin
    bit bus_g, loc_g, d_exp, dir;
    @(posedge clk);
    if (rst) begin
      m_dir.delete();
      m_pend_local = 1'b0;
      m_rvalid     = 1'b0;
      m_rdata      = '0;
      m_err        = 1'b0;
      m_rdata_dc   = 1'b0;
    end else begin
      bus_g    = exp_a_valid() && tl_d2h.a_ready;
      loc_g    = exp_loc_gnt();
      d_exp    = tl_d2h.d_valid && (m_dir.size() > 0);
      m_rvalid = 1'b0;
      if (d_exp) begin
        dir        = m_dir.pop_front();
        m_rvalid   = 1'b1;
        m_err      = tl_d2h.d_error || (tl_d2h.d_source != Sid) ||
                     (dir ? (tl_d2h.d_opcode != AccessAck) : (tl_d2h.d_opcode != AccessAckData));
        m_rdata    = dir ? 32'h0 : tl_d2h.d_data;
        m_rdata_dc = !dir && m_err;
      end else if (loc_g) begin
        m_rvalid   = 1'b1;
        m_err      = 1'b1;
        m_rdata    = '0;
        m_rdata_dc = 1'b0;
      end
      if (bus_g) m_dir.push_back(core.we_i);
      m_pend_local = loc_g;
    end
    cmp_en = 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("a_valid", tl_h2d.a_valid, exp_a_valid());
      chk("gnt", core.gnt_o, (exp_a_valid() && tl_d2h.a_ready) || exp_loc_gnt());
      chk("d_ready", tl_h2d.d_ready, 1);
      if (exp_a_valid()) begin
        chk("a_opcode", tl_h2d.a_opcode, exp_op());
        chk("a_mask", tl_h2d.a_mask, core.we_i ? core.be_i : 4'hF);
        chk("a_address", tl_h2d.a_address, {core.addr_i[31:2], 2'b00});
        chk("a_size", tl_h2d.a_size, 2);
        chk("a_source", tl_h2d.a_source, Sid);
        chk("a_param", tl_h2d.a_param, 0);
        chk("a_data", tl_h2d.a_data, core.wdata_i);
      end
      chk("rvalid", core.rvalid_o, m_rvalid);
      chk("err", core.err_o, m_err);
      if (!m_rdata_dc) chk("rdata", core.rdata_o, m_rdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold a request until granted (bounded); returns one cycle after the grant edge.
  task automatic issue(input bit we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input bit exp_bus, input logic [2:0] eop,
                       input logic [3:0] emask);
    bit done = 1'b0;
    core.req_i   = 1'b1;
    core.we_i    = we;
    core.addr_i  = addr;
    core.be_i    = be;
    core.wdata_i = wd;
    for (int i = 0; i < 30 && !done; i++) begin
      #1;
      if (core.gnt_o === 1'b1) begin
        done = 1'b1;
        chk("grant_a_valid", tl_h2d.a_valid, exp_bus);
        if (exp_bus) begin
          chk("grant_opcode", tl_h2d.a_opcode, eop);
          chk("grant_mask", tl_h2d.a_mask, emask);
        end
      end
      step();
    end
    core.req_i = 1'b0;
    chk("grant_seen", done, 1);
  endtask

  task automatic dbeat(input tl_d_m_op op, input logic [31:0] data, input bit derr,
                       input logic [7:0] src);
    tl_d2h.d_valid  = 1'b1;
    tl_d2h.d_opcode = op;
    tl_d2h.d_data   = data;
    tl_d2h.d_error  = derr;
    tl_d2h.d_source = src;
    step();
    tl_d2h.d_valid  = 1'b0;
    tl_d2h.d_error  = 1'b0;
    tl_d2h.d_source = Sid;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    tl_d2h         = '0;
    tl_d2h.a_ready = 1'b1;
    tl_d2h.d_source = Sid;
    core.req_i     = 1'b1;
    core.we_i      = 1'b0;
    core.addr_i    = 32'h40;
    core.be_i      = 4'h0;
    core.wdata_i   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_valid", tl_h2d.a_valid, 0);
    chk("rst_gnt", core.gnt_o, 0);
    chk("rst_rvalid", core.rvalid_o, 0);
    chk("rst_rdata", core.rdata_o, 0);
    chk("rst_err", core.err_o, 0);
    rst        = 1'b0;
    core.req_i = 1'b0;
    step();

    // Read
    issue(1'b0, 32'h100, 4'h0, 32'h0, 1'b1, Get, 4'hF);
    dbeat(AccessAckData, 32'hDEADBEEF, 1'b0, Sid);
    chk("rd_rvalid", core.rvalid_o, 1);
    chk("rd_rdata", core.rdata_o, 32'hDEADBEEF);
    chk("rd_err", core.err_o, 0);
    step();
    chk("rd_pulse", core.rvalid_o, 0);
    chk("rd_hold", core.rdata_o, 32'hDEADBEEF);

    // Writes: partial then full
    issue(1'b1, 32'h200, 4'h3, 32'h1234, 1'b1, PutPartialData, 4'h3);
    dbeat(AccessAck, 32'hFFFF_FFFF, 1'b0, Sid);
    chk("wr_rvalid", core.rvalid_o, 1);
    chk("wr_rdata", core.rdata_o, 0);
    chk("wr_err", core.err_o, 0);
    issue(1'b1, 32'h204, 4'hF, 32'hCAFE, 1'b1, PutFullData, 4'hF);
    dbeat(AccessAck, 32'h0, 1'b0, Sid);
    chk("wrf_rvalid", core.rvalid_o, 1);

    // Back-pressure, then limit of two outstanding
    tl_d2h.a_ready = 1'b0;
    fork
      issue(1'b0, 32'h300, 4'h0, 32'h0, 1'b1, Get, 4'hF);
      begin
        repeat (3) step();
        #1;
        chk("bp_gnt", core.gnt_o, 0);
        chk("bp_a_valid", tl_h2d.a_valid, 1);
        repeat (2) step();
        tl_d2h.a_ready = 1'b1;
      end
    join
    issue(1'b0, 32'h304, 4'h0, 32'h0, 1'b1, Get, 4'hF);
    fork
      begin
        issue(1'b0, 32'h308, 4'h0, 32'h0, 1'b1, Get, 4'hF);
        issue(1'b0, 32'h30C, 4'h0, 32'h0, 1'b1, Get, 4'hF);
        issue(1'b0, 32'h310, 4'h0, 32'h0, 1'b1, Get, 4'hF);
      end
      begin
        dbeat(AccessAckData, 32'hA0, 1'b0, Sid);
        dbeat(AccessAckData, 32'hA1, 1'b0, Sid);
        step();
        #1;
        chk("full_gnt", core.gnt_o, 0);
        chk("full_a_valid", tl_h2d.a_valid, 0);
        repeat (2) step();
        dbeat(AccessAckData, 32'hA2, 1'b0, Sid);
        dbeat(AccessAckData, 32'hA3, 1'b0, Sid);
        dbeat(AccessAckData, 32'hA4, 1'b0, Sid);
        chk("full_last_rdata", core.rdata_o, 32'hA4);
      end
    join

    // Misaligned while one read is outstanding
    issue(1'b0, 32'h400, 4'h0, 32'h0, 1'b1, Get, 4'hF);
    fork
      issue(1'b0, 32'h102, 4'hF, 32'h0, 1'b0, Get, 4'hF);
      begin
        repeat (2) step();
        #1;
        chk("mis_hold_gnt", core.gnt_o, 0);
        chk("mis_a_valid", tl_h2d.a_valid, 0);
        step();
        dbeat(AccessAckData, 32'h55, 1'b0, Sid);
        chk("mis_prior_rdata", core.rdata_o, 32'h55);
      end
    join
    chk("mis_rvalid", core.rvalid_o, 1);
    chk("mis_err", core.err_o, 1);
    chk("mis_rdata", core.rdata_o, 0);

    // Error responses
    issue(1'b0, 32'h500, 4'h0, 32'h0, 1'b1, Get, 4'hF);
    dbeat(AccessAckData, 32'h77, 1'b1, Sid);
    chk("derr_err", core.err_o, 1);
    issue(1'b0, 32'h504, 4'h0, 32'h0, 1'b1, Get, 4'hF);
    dbeat(AccessAckData, 32'h88, 1'b0, 8'h05);
    chk("src_err", core.err_o, 1);
    issue(1'b1, 32'h508, 4'hF, 32'h99, 1'b1, PutFullData, 4'hF);
    dbeat(AccessAckData, 32'h99, 1'b0, Sid);
    chk("wdir_err", core.err_o, 1);
    chk("wdir_rdata", core.rdata_o, 0);
    issue(1'b0, 32'h50C, 4'h0, 32'h0, 1'b1, Get, 4'hF);
    dbeat(AccessAck, 32'h0, 1'b0, Sid);
    chk("rdir_err", core.err_o, 1);
    dbeat(AccessAckData, 32'hBAD, 1'b0, Sid);
    chk("unexp_rvalid", core.rvalid_o, 0);

    // Reset with two outstanding
    issue(1'b0, 32'h600, 4'h0, 32'h0, 1'b1, Get, 4'hF);
    issue(1'b0, 32'h604, 4'h0, 32'h0, 1'b1, Get, 4'hF);
    rst         = 1'b1;
    core.req_i  = 1'b1;
    core.we_i   = 1'b0;
    core.addr_i = 32'h700;
    #1;
    chk("midrst_gnt", core.gnt_o, 0);
    chk("midrst_a_valid", tl_h2d.a_valid, 0);
    step();
    rst        = 1'b0;
    core.req_i = 1'b0;
    chk("midrst_rvalid", core.rvalid_o, 0);
    chk("midrst_rdata", core.rdata_o, 0);
    dbeat(AccessAckData, 32'h11, 1'b0, Sid);
    chk("late1_rvalid", core.rvalid_o, 0);
    dbeat(AccessAckData, 32'h22, 1'b0, Sid);
    chk("late2_rvalid", core.rvalid_o, 0);
    issue(1'b0, 32'h608, 4'h0, 32'h0, 1'b1, Get, 4'hF);
    dbeat(AccessAckData, 32'h600DF00D, 1'b0, Sid);
    chk("post_rvalid", core.rvalid_o, 1);
    chk("post_rdata", core.rdata_o, 32'h600DF00D);
    chk("post_err", core.err_o, 0);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
